// File: rtl/bp_top_pkg.sv
// Shared BlackParrot top-level types: accelerator kinds, the vector
// dot-product CSR map, region codes, compute modes and FSM states.
package bp_top_pkg;

    typedef enum logic [1:0] {
        e_sacc_none,
        e_sacc_vdp,
        e_sacc_scratchpad,
        e_sacc_loopback
    } bp_sacc_type_e;

    localparam logic [3:0] region_csr_gp = 4'h0;
    localparam logic [3:0] region_a_gp   = 4'h1;
    localparam logic [3:0] region_b_gp   = 4'h2;

    localparam logic [11:0] csr_len_gp    = 12'h000;
    localparam logic [11:0] csr_mode_gp   = 12'h008;
    localparam logic [11:0] csr_start_gp  = 12'h010;
    localparam logic [11:0] csr_status_gp = 12'h018;
    localparam logic [11:0] csr_result_gp = 12'h020;
    localparam logic [11:0] csr_cycles_gp = 12'h028;

    typedef enum logic [1:0] {
        e_mode_dot  = 2'd0,
        e_mode_sum  = 2'd1,
        e_mode_sqd  = 2'd2,
        e_mode_rsvd = 2'd3
    } bp_sacc_mode_e;

    typedef enum logic [1:0] {
        e_idle,
        e_run,
        e_drain
    } bp_sacc_state_e;

endpackage

// File: rtl/bp_sacc_vdp_lanes_if.sv
// Host command/response channel of the vector dot-product accelerator,
// both directions using valid / ready-and handshakes.
interface bp_sacc_vdp_lanes_if
 #(parameter int addr_width_p = 16
  ,parameter int data_width_p = 64)
  (input logic clk_i);

    logic                    cmd_v;
    logic                    cmd_w;
    logic [addr_width_p-1:0] cmd_addr;
    logic [data_width_p-1:0] cmd_data;
    logic                    cmd_ready_and;
    logic                    resp_v;
    logic [data_width_p-1:0] resp_data;
    logic                    resp_ready_and;

    modport master (
        input  clk_i,
        output cmd_v, cmd_w, cmd_addr, cmd_data,
        input  cmd_ready_and,
        input  resp_v, resp_data,
        output resp_ready_and
    );

    modport slave (
        input  clk_i,
        input  cmd_v, cmd_w, cmd_addr, cmd_data,
        output cmd_ready_and,
        output resp_v, resp_data,
        input  resp_ready_and
    );

endinterface

// File: rtl/bp_sacc_lane_reduce.sv
// Per-lane operate (product / pass / squared difference) followed by a
// lane reduction and one output register stage.
module bp_sacc_lane_reduce
  import bp_top_pkg::*;
 #(parameter int lanes_p = 4
  ,parameter int data_width_p = 64)
  (input  logic                                  clk_i
  ,input  logic                                  reset_i
  ,input  logic                                  v_i
  ,input  bp_sacc_mode_e                         mode_i
  ,input  logic [lanes_p-1:0]                    mask_i
  ,input  logic [lanes_p-1:0][data_width_p-1:0]  a_i
  ,input  logic [lanes_p-1:0][data_width_p-1:0]  b_i
  ,output logic                                  v_o
  ,output logic [data_width_p-1:0]               sum_o);

    logic [lanes_p-1:0][data_width_p-1:0] term;
    logic [data_width_p-1:0]              sum_n;

    // Products keep only the low data_width_p bits (modular arithmetic).
    for (genvar l = 0; l < lanes_p; l++) begin : g_lane
        logic [data_width_p-1:0] diff;
        logic [data_width_p-1:0] t;
        assign diff = a_i[l] - b_i[l];
        always_comb begin
            t = '0;
            if (mask_i[l])
                unique case (mode_i)
                    e_mode_dot: t = a_i[l] * b_i[l];
                    e_mode_sum: t = a_i[l];
                    e_mode_sqd: t = diff * diff;
                    default:    t = '0;
                endcase
        end
        assign term[l] = t;
    end

    always_comb begin
        sum_n = '0;
        for (int l = 0; l < lanes_p; l++)
            sum_n = sum_n + term[l];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o   <= 1'b0;
            sum_o <= '0;
        end else begin
            v_o   <= v_i;
            sum_o <= sum_n;
        end
    end

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One-write one-read register-file memory: synchronous write,
// asynchronous read.
module bsg_mem_1r1w
 #(parameter int width_p = 64
  ,parameter int els_p = 16
  ,localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1)
  (input  logic                     w_clk_i
  ,input  logic                     w_v_i
  ,input  logic [addr_width_lp-1:0] w_addr_i
  ,input  logic [width_p-1:0]       w_data_i
  ,input  logic [addr_width_lp-1:0] r_addr_i
  ,output logic [width_p-1:0]       r_data_o);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i)
            mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_sacc_vdp_lanes.sv
// Vector dot-product accelerator: host-loaded A/B banks, lanes_p
// elements per cycle into a registered reduction, CSR-controlled.
module bp_sacc_vdp_lanes
  import bp_top_pkg::*;
 #(parameter int lanes_p = 4
  ,parameter int max_len_p = 64
  ,parameter int data_width_p = 64
  ,parameter int addr_width_p = 16)
  (input  logic                    clk_i
  ,input  logic                    reset_i
  ,input  logic                    io_cmd_v_i
  ,input  logic                    io_cmd_w_i
  ,input  logic [addr_width_p-1:0] io_cmd_addr_i
  ,input  logic [data_width_p-1:0] io_cmd_data_i
  ,output logic                    io_cmd_ready_and_o
  ,output logic                    io_resp_v_o
  ,output logic [data_width_p-1:0] io_resp_data_o
  ,input  logic                    io_resp_ready_and_i);

    localparam int rows_lp  = max_len_p / lanes_p;
    localparam int row_w_lp = (rows_lp > 1) ? $clog2(rows_lp) : 1;
    localparam int idx_w_lp = (max_len_p > 1) ? $clog2(max_len_p) : 1;
    localparam int len_w_lp = $clog2(max_len_p + 1);

    bp_sacc_state_e state_r, state_n;

    logic [data_width_p-1:0] len_r, result_r, cycles_r, acc_r;
    logic [data_width_p-1:0] resp_data_r, rdata;
    logic [1:0]              mode_r;
    logic                    done_r, err_r, resp_v_r;

    logic [len_w_lp-1:0] beat_r, eff_len, n_beats;
    logic busy, run_v, drain_v, last_beat, accept;
    logic wr_ok, wr_busy;
    logic err_set, status_rd, len_we, mode_we, start, a_we, b_we;

    logic [3:0]          region;
    logic [8:0]          idx;
    logic [11:0]         offset;
    logic                in_range;
    logic [idx_w_lp-1:0] idx_lo;
    logic [row_w_lp-1:0] wr_row, rd_row;
    logic                unused_addr;

    logic [lanes_p-1:0]                   bank_hit, mask;
    logic [lanes_p-1:0][data_width_p-1:0] a_row, b_row;
    logic [data_width_p-1:0]              a_io, b_io, red_sum;
    logic                                 red_v;

    assign region      = io_cmd_addr_i[15:12];
    assign idx         = io_cmd_addr_i[11:3];
    assign offset      = io_cmd_addr_i[11:0];
    assign unused_addr = ^io_cmd_addr_i[2:0];
    assign in_range    = 32'(idx) < 32'(max_len_p);
    assign idx_lo      = idx_w_lp'(idx);
    assign wr_row      = row_w_lp'(32'(idx) / 32'(lanes_p));
    assign rd_row      = row_w_lp'(beat_r);

    assign eff_len = (len_r > data_width_p'(max_len_p))
                   ? len_w_lp'(max_len_p)
                   : len_w_lp'(len_r);
    assign n_beats = len_w_lp'((32'(eff_len) + 32'(lanes_p) - 32'd1)
                               / 32'(lanes_p));
    assign last_beat = (beat_r == n_beats - len_w_lp'(1));

    for (genvar l = 0; l < lanes_p; l++) begin : g_bank
        assign bank_hit[l] = (32'(idx) % 32'(lanes_p)) == 32'(l);
        assign mask[l] = (32'(beat_r) * 32'(lanes_p) + 32'(l))
                         < 32'(eff_len);

        bsg_mem_1r1w #(.width_p(data_width_p), .els_p(rows_lp)) a_bank (
            .w_clk_i  (clk_i),
            .w_v_i    (a_we & bank_hit[l]),
            .w_addr_i (wr_row),
            .w_data_i (io_cmd_data_i),
            .r_addr_i (rd_row),
            .r_data_o (a_row[l])
        );

        bsg_mem_1r1w #(.width_p(data_width_p), .els_p(rows_lp)) b_bank (
            .w_clk_i  (clk_i),
            .w_v_i    (b_we & bank_hit[l]),
            .w_addr_i (wr_row),
            .w_data_i (io_cmd_data_i),
            .r_addr_i (rd_row),
            .r_data_o (b_row[l])
        );
    end

    // Shadow copies give host reads their own port, so reads while busy
    // never contend with the row the compute pipe is fetching.
    bsg_mem_1r1w #(.width_p(data_width_p), .els_p(max_len_p)) a_shadow (
        .w_clk_i  (clk_i),
        .w_v_i    (a_we),
        .w_addr_i (idx_lo),
        .w_data_i (io_cmd_data_i),
        .r_addr_i (idx_lo),
        .r_data_o (a_io)
    );

    bsg_mem_1r1w #(.width_p(data_width_p), .els_p(max_len_p)) b_shadow (
        .w_clk_i  (clk_i),
        .w_v_i    (b_we),
        .w_addr_i (idx_lo),
        .w_data_i (io_cmd_data_i),
        .r_addr_i (idx_lo),
        .r_data_o (b_io)
    );

    bp_sacc_lane_reduce #(
        .lanes_p      (lanes_p),
        .data_width_p (data_width_p)
    ) reduce (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (run_v),
        .mode_i  (bp_sacc_mode_e'(mode_r)),
        .mask_i  (mask),
        .a_i     (a_row),
        .b_i     (b_row),
        .v_o     (red_v),
        .sum_o   (red_sum)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= e_idle;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle:  if (start)
                         state_n = (eff_len == '0) ? e_drain : e_run;
            e_run:   if (last_beat)
                         state_n = e_drain;
            e_drain: state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    always_comb begin
        busy    = (state_r != e_idle);
        run_v   = (state_r == e_run);
        drain_v = (state_r == e_drain);
    end

    assign accept  = io_cmd_v_i & io_cmd_ready_and_o & ~reset_i;
    assign wr_ok   = io_cmd_w_i & ~busy;
    assign wr_busy = io_cmd_w_i & busy;

    always_comb begin
        rdata     = '0;
        err_set   = 1'b0;
        status_rd = 1'b0;
        len_we    = 1'b0;
        mode_we   = 1'b0;
        start     = 1'b0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        if (accept)
            unique case (1'b1)
                (region == region_csr_gp):
                    unique case (offset)
                        csr_len_gp: begin
                            rdata   = len_r;
                            len_we  = wr_ok;
                            err_set = wr_busy;
                        end
                        csr_mode_gp: begin
                            rdata   = data_width_p'(mode_r);
                            mode_we = wr_ok;
                            err_set = wr_busy;
                        end
                        csr_start_gp: begin
                            start   = wr_ok;
                            err_set = ~io_cmd_w_i | busy;
                        end
                        csr_status_gp: begin
                            rdata     = data_width_p'({err_r, done_r, busy});
                            status_rd = ~io_cmd_w_i;
                            err_set   = io_cmd_w_i;
                        end
                        csr_result_gp: begin
                            rdata   = result_r;
                            err_set = io_cmd_w_i;
                        end
                        csr_cycles_gp: begin
                            rdata   = cycles_r;
                            err_set = io_cmd_w_i;
                        end
                        default: err_set = 1'b1;
                    endcase
                (region == region_a_gp): begin
                    rdata   = in_range ? a_io : '0;
                    a_we    = in_range & wr_ok;
                    err_set = ~in_range | wr_busy;
                end
                (region == region_b_gp): begin
                    rdata   = in_range ? b_io : '0;
                    b_we    = in_range & wr_ok;
                    err_set = ~in_range | wr_busy;
                end
                default: err_set = 1'b1;
            endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_r    <= '0;
            mode_r   <= '0;
            beat_r   <= '0;
            acc_r    <= '0;
            result_r <= '0;
            cycles_r <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (len_we)
                len_r <= io_cmd_data_i;
            if (mode_we)
                mode_r <= io_cmd_data_i[1:0];
            if (err_set)
                err_r <= 1'b1;
            else if (status_rd)
                err_r <= 1'b0;
            if (start) begin
                done_r   <= 1'b0;
                acc_r    <= '0;
                beat_r   <= '0;
                cycles_r <= data_width_p'(1);
            end else begin
                if (run_v | drain_v)
                    cycles_r <= cycles_r + data_width_p'(1);
                if (run_v)
                    beat_r <= beat_r + len_w_lp'(1);
                if (red_v)
                    acc_r <= acc_r + red_sum;
                // The last beat leaves the reduction register during DRAIN.
                if (drain_v) begin
                    result_r <= acc_r + (red_v ? red_sum : '0);
                    done_r   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_r    <= 1'b0;
            resp_data_r <= '0;
        end else if (accept) begin
            resp_v_r    <= 1'b1;
            resp_data_r <= io_cmd_w_i ? '0 : rdata;
        end else if (io_resp_ready_and_i) begin
            resp_v_r    <= 1'b0;
        end
    end

    assign io_cmd_ready_and_o = ~resp_v_r | io_resp_ready_and_i;
    assign io_resp_v_o        = resp_v_r;
    assign io_resp_data_o     = resp_data_r;

endmodule

// File: tb/tb_bp_sacc_vdp_lanes.sv
// Directed bench for bp_sacc_vdp_lanes: CSR reset values, the four
// modes, masking, length clamp, busy protection, backpressure, reset.
module tb_bp_sacc_vdp_lanes;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bp_sacc_vdp_lanes_if #(.addr_width_p(16), .data_width_p(64)) io (
        .clk_i (clk)
    );

    bp_sacc_vdp_lanes #(
        .lanes_p      (4),
        .max_len_p    (64),
        .data_width_p (64),
        .addr_width_p (16)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .io_cmd_v_i          (io.cmd_v),
        .io_cmd_w_i          (io.cmd_w),
        .io_cmd_addr_i       (io.cmd_addr),
        .io_cmd_data_i       (io.cmd_data),
        .io_cmd_ready_and_o  (io.cmd_ready_and),
        .io_resp_v_o         (io.resp_v),
        .io_resp_data_o      (io.resp_data),
        .io_resp_ready_and_i (io.resp_ready_and)
    );

    localparam logic [15:0] LEN_A    = 16'h0000;
    localparam logic [15:0] MODE_A   = 16'h0008;
    localparam logic [15:0] START_A  = 16'h0010;
    localparam logic [15:0] STATUS_A = 16'h0018;
    localparam logic [15:0] RESULT_A = 16'h0020;
    localparam logic [15:0] CYCLES_A = 16'h0028;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response.
    task automatic txn(input logic w, input logic [15:0] a,
                       input logic [63:0] d, output logic [63:0] r);
        int n = 0;
        io.cmd_v = 1'b1;
        io.cmd_w = w;
        io.cmd_addr = a;
        io.cmd_data = d;
        while (!io.cmd_ready_and && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20)
            check("cmd_ready_wait", 64'(io.cmd_ready_and), 64'd1);
        @(posedge clk);
        @(negedge clk);
        io.cmd_v = 1'b0;
        check("resp_v", 64'(io.resp_v), 64'd1);
        r = io.resp_data;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        logic [63:0] r;
        txn(1'b1, a, d, r);
        check("wr_resp_zero", r, 64'd0);
    endtask

    task automatic rd(input logic [15:0] a, output logic [63:0] r);
        txn(1'b0, a, 64'd0, r);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a,
                          input logic [63:0] exp);
        logic [63:0] r;
        rd(a, r);
        check(tag, r, exp);
    endtask

    task automatic poll_done(output logic [63:0] st);
        st = '0;
        for (int i = 0; i < 40 && !st[1]; i++)
            rd(STATUS_A, st);
        check("done", 64'(st[1]), 64'd1);
    endtask

    task automatic run(input logic [63:0] len, input logic [63:0] mode);
        logic [63:0] st;
        wr(LEN_A, len);
        wr(MODE_A, mode);
        wr(START_A, 64'd1);
        poll_done(st);
    endtask

    initial begin
        logic [63:0] st;
        io.cmd_v = 1'b0;
        io.cmd_w = 1'b0;
        io.cmd_addr = '0;
        io.cmd_data = '0;
        io.resp_ready_and = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 64'(io.cmd_ready_and), 64'd1);
        check("rst_resp_v", 64'(io.resp_v), 64'd0);
        rd_chk("rst_status", STATUS_A, 64'd0);
        rd_chk("rst_len", LEN_A, 64'd0);
        rd_chk("rst_mode", MODE_A, 64'd0);
        rd_chk("rst_result", RESULT_A, 64'd0);
        rd_chk("rst_cycles", CYCLES_A, 64'd0);

        for (int i = 0; i < 8; i++) begin
            wr(16'h1000 + 16'(i * 8), 64'(i + 1));
            wr(16'h2000 + 16'(i * 8), 64'd2);
        end
        rd_chk("a3_rb", 16'h1018, 64'd4);
        rd_chk("b7_rb", 16'h2038, 64'd2);

        run(64'd8, 64'd0);
        rd_chk("dot_result", RESULT_A, 64'd72);
        rd_chk("dot_cycles", CYCLES_A, 64'd4);

        run(64'd5, 64'd1);
        rd_chk("part_result", RESULT_A, 64'd15);
        rd_chk("part_cycles", CYCLES_A, 64'd4);

        run(64'd4, 64'd2);
        rd_chk("sqd_result", RESULT_A, 64'd6);
        rd_chk("sqd_cycles", CYCLES_A, 64'd3);

        run(64'd8, 64'd3);
        rd_chk("rsvd_result", RESULT_A, 64'd0);

        run(64'd100, 64'd0);
        rd_chk("clamp_cycles", CYCLES_A, 64'd18);
        rd_chk("clamp_len", LEN_A, 64'd100);

        wr(LEN_A, 64'd0);
        wr(START_A, 64'd1);
        rd_chk("zero_busy", STATUS_A, 64'h1);
        rd_chk("zero_done", STATUS_A, 64'h2);
        rd_chk("zero_result", RESULT_A, 64'd0);
        rd_chk("zero_cycles", CYCLES_A, 64'd2);

        wr(LEN_A, 64'd8);
        wr(MODE_A, 64'd0);
        wr(START_A, 64'd1);
        wr(16'h1000, 64'd99);
        wr(START_A, 64'd1);
        rd_chk("busy_err", STATUS_A, 64'h5);
        poll_done(st);
        check("busy_err_clr", st, 64'h2);
        rd_chk("busy_err_stay", STATUS_A, 64'h2);
        rd_chk("busy_result", RESULT_A, 64'd72);
        rd_chk("busy_a0", 16'h1000, 64'd1);
        rd_chk("busy_cycles", CYCLES_A, 64'd4);

        wr(16'h1000, 64'd0);
        wr(16'h2000, 64'h8000_0000_0000_0000);
        run(64'd1, 64'd2);
        rd_chk("wrap_result", RESULT_A, 64'd0);
        rd_chk("wrap_cycles", CYCLES_A, 64'd3);

        rd_chk("unmap_rd", 16'h3000, 64'd0);
        rd_chk("unmap_err", STATUS_A, 64'h6);
        rd_chk("unmap_clr", STATUS_A, 64'h2);
        rd_chk("oor_rd", 16'h1200, 64'd0);
        rd_chk("oor_err", STATUS_A, 64'h6);

        @(negedge clk);
        io.resp_ready_and = 1'b0;
        io.cmd_v = 1'b1;
        io.cmd_w = 1'b0;
        io.cmd_addr = LEN_A;
        @(posedge clk);
        @(negedge clk);
        io.cmd_addr = MODE_A;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_v", 64'(io.resp_v), 64'd1);
            check("bp_data", io.resp_data, 64'd1);
            check("bp_cmd_rdy", 64'(io.cmd_ready_and), 64'd0);
            @(negedge clk);
        end
        io.resp_ready_and = 1'b1;
        #1;
        check("bp_release", 64'(io.cmd_ready_and), 64'd1);
        @(posedge clk);
        @(negedge clk);
        io.cmd_v = 1'b0;
        check("bp_second_v", 64'(io.resp_v), 64'd1);
        check("bp_second", io.resp_data, 64'd2);
        @(negedge clk);
        check("bp_drained", 64'(io.resp_v), 64'd0);

        wr(LEN_A, 64'd64);
        io.cmd_v = 1'b1;
        io.cmd_w = 1'b1;
        io.cmd_addr = START_A;
        io.cmd_data = 64'd1;
        @(posedge clk);
        @(negedge clk);
        io.cmd_v = 1'b0;
        io.resp_ready_and = 1'b0;
        reset = 1'b1;
        check("mid_pending", 64'(io.resp_v), 64'd1);
        @(negedge clk);
        check("rst_drop_resp", 64'(io.resp_v), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        io.resp_ready_and = 1'b1;
        check("rst2_ready", 64'(io.cmd_ready_and), 64'd1);
        check("rst2_resp_v", 64'(io.resp_v), 64'd0);
        rd_chk("rst2_status", STATUS_A, 64'd0);
        rd_chk("rst2_result", RESULT_A, 64'd0);
        rd_chk("rst2_len", LEN_A, 64'd0);
        rd_chk("rst2_cycles", CYCLES_A, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
